// File: rtl/uart_xcvr_if.sv
// CPU-side register bus of the UART transceiver: TX request, RX FIFO head and sticky error flags.
interface uart_xcvr_if #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned RX_FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 err_clear;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic [CNT_W-1:0]     rx_count;

    modport master (
        output data_in, data_in_valid, data_out_ready, err_clear,
        input  data_in_ready, data_out, data_out_valid,
               rx_parity_err, rx_frame_err, rx_overrun, rx_count
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready, err_clear,
        output data_in_ready, data_out, data_out_valid,
               rx_parity_err, rx_frame_err, rx_overrun, rx_count
    );
endinterface

// File: rtl/uart_xcvr.sv
// Parametrised UART transceiver: configurable width/parity/stop bits, FWFT receive FIFO,
// sticky receive error flags.
module uart_xcvr #(
    parameter int unsigned CLOCK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned RX_FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       serial_out,
    uart_xcvr_if.slave bus
);
    localparam int unsigned BIT_T  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_T = BIT_T / 2;
    localparam int unsigned TCNT_W = $clog2(BIT_T);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state, tx_state_n;
    logic [TCNT_W-1:0]    tx_cnt, tx_cnt_n;
    logic [IDX_W-1:0]     tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_out, tx_out_n;
    logic                 tx_rdy, tx_rdy_n;
    logic                 tx_bit_end_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_out   <= 1'b1;
            tx_rdy   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_out   <= tx_out_n;
            tx_rdy   <= tx_rdy_n;
        end
    end

    // serial_out is registered, so each branch loads the level of the bit that starts next
    always_comb begin
        tx_state_n   = tx_state;
        tx_cnt_n     = tx_cnt;
        tx_idx_n     = tx_idx;
        tx_shift_n   = tx_shift;
        tx_par_n     = tx_par;
        tx_out_n     = tx_out;
        tx_bit_end_c = (tx_cnt == TCNT_W'(BIT_T - 1));
        if (tx_state != S_IDLE) begin
            tx_cnt_n = tx_bit_end_c ? '0 : tx_cnt + TCNT_W'(1);
        end
        case (tx_state)
            S_IDLE: begin
                tx_out_n = 1'b1;
                if (bus.data_in_valid && tx_rdy) begin
                    tx_shift_n = bus.data_in;
                    tx_par_n   = (PARITY == 1) ? ~(^bus.data_in) : ^bus.data_in;
                    tx_cnt_n   = '0;
                    tx_out_n   = 1'b0;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                if (tx_bit_end_c) begin
                    tx_out_n   = tx_shift[0];
                    tx_idx_n   = '0;
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_bit_end_c) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == IDX_W'(DATA_BITS - 1)) begin
                        tx_idx_n = '0;
                        if (PARITY != 0) begin
                            tx_out_n   = tx_par;
                            tx_state_n = S_PARITY;
                        end else begin
                            tx_out_n   = 1'b1;
                            tx_state_n = S_STOP;
                        end
                    end else begin
                        tx_idx_n = tx_idx + IDX_W'(1);
                        tx_out_n = tx_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end_c) begin
                    tx_out_n   = 1'b1;
                    tx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_bit_end_c) begin
                    tx_out_n = 1'b1;
                    if (tx_idx == IDX_W'(STOP_BITS - 1)) begin
                        tx_state_n = S_IDLE;
                    end else begin
                        tx_idx_n = tx_idx + IDX_W'(1);
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        tx_rdy_n = (tx_state_n == S_IDLE);
    end

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2;
    state_t               rx_state, rx_state_n;
    logic [TCNT_W-1:0]    rx_cnt, rx_cnt_n;
    logic [IDX_W-1:0]     rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_par, rx_par_n;
    logic                 rx_stop_bad, rx_stop_bad_n;
    logic                 rx_hold, rx_hold_n;
    logic                 rx_sample_c, rx_par_bad_c;
    logic                 rx_push_c, rx_ferr_c, rx_perr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_stop_bad <= 1'b0;
            rx_hold     <= 1'b0;
        end else begin
            rx_s1       <= serial_in;
            rx_s2       <= rx_s1;
            rx_state    <= rx_state_n;
            rx_cnt      <= rx_cnt_n;
            rx_idx      <= rx_idx_n;
            rx_shift    <= rx_shift_n;
            rx_par      <= rx_par_n;
            rx_stop_bad <= rx_stop_bad_n;
            rx_hold     <= rx_hold_n;
        end
    end

    // rx_hold keeps IDLE from re-arming on a held-low break until the line goes high
    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt;
        rx_idx_n      = rx_idx;
        rx_shift_n    = rx_shift;
        rx_par_n      = rx_par;
        rx_stop_bad_n = rx_stop_bad;
        rx_hold_n     = rx_hold;
        rx_push_c     = 1'b0;
        rx_ferr_c     = 1'b0;
        rx_perr_c     = 1'b0;
        rx_sample_c   = (rx_state == S_START) ? (rx_cnt == TCNT_W'(HALF_T - 1))
                                              : (rx_cnt == TCNT_W'(BIT_T - 1));
        rx_par_bad_c  = (PARITY == 1) ? ~(^rx_shift ^ rx_par)
                      : (PARITY == 2) ?  (^rx_shift ^ rx_par) : 1'b0;
        if (rx_state != S_IDLE) begin
            rx_cnt_n = rx_sample_c ? '0 : rx_cnt + TCNT_W'(1);
        end
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_hold) begin
                    if (rx_s2) rx_hold_n = 1'b0;
                end else if (!rx_s2) begin
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (rx_sample_c) begin
                    if (rx_s2) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_idx_n   = '0;
                        rx_state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_sample_c) begin
                    rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_W'(DATA_BITS - 1)) begin
                        rx_idx_n      = '0;
                        rx_stop_bad_n = 1'b0;
                        rx_state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_n = rx_idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (rx_sample_c) begin
                    rx_par_n   = rx_s2;
                    rx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample_c) begin
                    rx_stop_bad_n = rx_stop_bad | ~rx_s2;
                    if (rx_idx == IDX_W'(STOP_BITS - 1)) begin
                        rx_state_n = S_IDLE;
                        if (rx_stop_bad | ~rx_s2) begin
                            rx_ferr_c = 1'b1;
                            rx_hold_n = 1'b1;
                        end else if (rx_par_bad_c) begin
                            rx_perr_c = 1'b1;
                        end else begin
                            rx_push_c = 1'b1;
                        end
                    end else begin
                        rx_idx_n = rx_idx + IDX_W'(1);
                    end
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // ---------------- receive FIFO and error flags ----------------
    logic [DATA_BITS-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 pop_c, full_c, wr_c, ovr_c;
    logic                 perr, ferr, ovr;

    assign pop_c  = (count != '0) && bus.data_out_ready;
    assign full_c = (count == CNT_W'(RX_FIFO_DEPTH));
    assign wr_c   = rx_push_c && (!full_c || pop_c);
    assign ovr_c  = rx_push_c && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (wr_c) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (wr_c)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_c) - CNT_W'(pop_c);
            // a new event in the same cycle as err_clear wins
            perr  <= rx_perr_c | (perr & ~bus.err_clear);
            ferr  <= rx_ferr_c | (ferr & ~bus.err_clear);
            ovr   <= ovr_c     | (ovr  & ~bus.err_clear);
        end
    end

    assign serial_out         = tx_out;
    assign bus.data_in_ready  = tx_rdy;
    assign bus.data_out       = fifo_mem[rd_ptr];
    assign bus.data_out_valid = (count != '0);
    assign bus.rx_count       = count;
    assign bus.rx_parity_err  = perr;
    assign bus.rx_frame_err   = ferr;
    assign bus.rx_overrun     = ovr;
endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr: one 8N1 instance driven directly, two parity instances in loopback.
module tb_uart_xcvr;
    localparam int unsigned TA = 5, NA = 10, DEPTH_A = 4;   // 8N1, depth 4
    localparam int unsigned TB = 5, NB = 11;                // 8E1 loopback
    localparam int unsigned TC = 6, NC = 11;                // 7O2 loopback
    localparam int unsigned NLOOP = 24;

    bit   clk = 1'b0;
    logic rst;
    logic line_a, so_a, so_b, so_c;
    int   checks = 0;
    int   errors = 0;
    int unsigned q_a[$], q_b[$], q_c[$];

    always #5 clk = ~clk;

    uart_xcvr_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(DEPTH_A)) aif ();
    uart_xcvr_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(8))       bif ();
    uart_xcvr_if #(.DATA_BITS(7), .RX_FIFO_DEPTH(8))       cif ();

    uart_xcvr #(.CLOCK_FREQ(50), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH_A)) u_a (
        .clk(clk), .rst(rst), .serial_in(line_a), .serial_out(so_a), .bus(aif));
    uart_xcvr #(.CLOCK_FREQ(50), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .RX_FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .serial_in(so_b), .serial_out(so_b), .bus(bif));
    uart_xcvr #(.CLOCK_FREQ(60), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(2), .RX_FIFO_DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .serial_in(so_c), .serial_out(so_c), .bus(cif));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line level of frame bit i: start 0, data LSB first, optional parity, then stop 1s
    function automatic logic frame_bit(input int unsigned d, input int unsigned i,
                                       input int unsigned dbits, input int unsigned par);
        int unsigned ones;
        ones = $countones(d & ((32'd1 << dbits) - 32'd1));
        if (i == 0) return 1'b0;
        if (i <= dbits) return logic'((d >> (i - 1)) & 32'd1);
        if (par != 0 && i == dbits + 1) return (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic send_a(input int unsigned d, input bit bad_stop);
        for (int unsigned i = 0; i < NA; i++) begin
            line_a = (bad_stop && i == NA - 1) ? 1'b0 : frame_bit(d, i, 8, 0);
            tick(TA);
        end
    endtask

    // Monitors: pop the expected queue whenever the DUT pops its FIFO
    always @(negedge clk) begin
        if (!rst && aif.data_out_valid && aif.data_out_ready) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_rx_pop: got 0x%0h with nothing expected", aif.data_out);
            end else chk("a_rx_data", 32'(aif.data_out), q_a.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && bif.data_out_valid && bif.data_out_ready) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_rx_pop: got 0x%0h with nothing expected", bif.data_out);
            end else chk("b_rx_data", 32'(bif.data_out), q_b.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && cif.data_out_valid && cif.data_out_ready) begin
            if (q_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_rx_pop: got 0x%0h with nothing expected", cif.data_out);
            end else chk("c_rx_data", 32'(cif.data_out), q_c.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dly;
        int unsigned w;
        int unsigned model_cnt;

        rst = 1'b1; line_a = 1'b1;
        aif.data_in = '0; aif.data_in_valid = 1'b0; aif.data_out_ready = 1'b0; aif.err_clear = 1'b0;
        bif.data_in = '0; bif.data_in_valid = 1'b0; bif.data_out_ready = 1'b1; bif.err_clear = 1'b0;
        cif.data_in = '0; cif.data_in_valid = 1'b0; cif.data_out_ready = 1'b1; cif.err_clear = 1'b0;
        tick(3);
        chk("rst_serial_out", 32'(so_a), 1);
        chk("rst_ready", 32'(aif.data_in_ready), 0);
        chk("rst_valid", 32'(aif.data_out_valid), 0);
        chk("rst_count", 32'(aif.rx_count), 0);
        chk("rst_flags", {29'd0, aif.rx_parity_err, aif.rx_frame_err, aif.rx_overrun}, 0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 32'(aif.data_in_ready), 1);

        // TX frame of 0x61 on the 8N1 instance; data_in changes right after the handshake
        aif.data_in = 8'h61; aif.data_in_valid = 1'b1;
        tick(1);
        aif.data_in_valid = 1'b0; aif.data_in = 8'h9E;
        for (int unsigned c = 0; c < NA * TA; c++) begin
            chk("a_tx_line", 32'(so_a), 32'(frame_bit(32'h61, c / TA, 8, 0)));
            chk("a_tx_busy", 32'(aif.data_in_ready), 0);
            tick(1);
        end
        chk("a_tx_ready_again", 32'(aif.data_in_ready), 1);
        chk("a_tx_idle_line", 32'(so_a), 1);

        // Randomised loopback on the parity instances; first character is 0x61
        fork
            begin
                int unsigned d, wb;
                for (int n = 0; n < NLOOP; n++) begin
                    d = (n == 0) ? 32'h61 : $urandom_range(0, 255);
                    wb = 0;
                    while (!bif.data_in_ready && wb < 200) begin tick(1); wb++; end
                    chk("b_ready", 32'(bif.data_in_ready), 1);
                    bif.data_in = 8'(d); bif.data_in_valid = 1'b1;
                    tick(1);
                    bif.data_in_valid = 1'b0; bif.data_in = ~8'(d);
                    q_b.push_back(d);
                    for (int unsigned i = 0; i < NB; i++) begin
                        chk("b_tx_bit", 32'(so_b), 32'(frame_bit(d, i, 8, 2)));
                        tick(TB);
                    end
                end
            end
            begin
                int unsigned d, wc;
                for (int n = 0; n < NLOOP; n++) begin
                    d = (n == 0) ? 32'h61 : $urandom_range(0, 127);
                    wc = 0;
                    while (!cif.data_in_ready && wc < 200) begin tick(1); wc++; end
                    chk("c_ready", 32'(cif.data_in_ready), 1);
                    cif.data_in = 7'(d); cif.data_in_valid = 1'b1;
                    tick(1);
                    cif.data_in_valid = 1'b0; cif.data_in = ~7'(d);
                    q_c.push_back(d);
                    for (int unsigned i = 0; i < NC; i++) begin
                        chk("c_tx_bit", 32'(so_c), 32'(frame_bit(d, i, 7, 1)));
                        tick(TC);
                    end
                end
            end
        join
        w = 0;
        while ((q_b.size() != 0 || q_c.size() != 0) && w < 500) begin tick(1); w++; end
        chk("b_rx_drained", q_b.size(), 0);
        chk("c_rx_drained", q_c.size(), 0);
        chk("b_flags", {29'd0, bif.rx_parity_err, bif.rx_frame_err, bif.rx_overrun}, 0);
        chk("c_flags", {29'd0, cif.rx_parity_err, cif.rx_frame_err, cif.rx_overrun}, 0);

        // Frame error followed by a break: exactly one error, then normal reception
        send_a(32'h41, 1'b1);
        tick(4);
        chk("ferr_set", 32'(aif.rx_frame_err), 1);
        chk("ferr_count", 32'(aif.rx_count), 0);
        chk("ferr_no_perr", 32'(aif.rx_parity_err), 0);
        aif.err_clear = 1'b1; tick(1); aif.err_clear = 1'b0;
        tick(3 * NA * TA);
        chk("break_single_err", 32'(aif.rx_frame_err), 0);
        line_a = 1'b1;
        tick(2 * TA);
        q_a.push_back(32'h42);
        send_a(32'h42, 1'b0);
        tick(TA);
        chk("after_break_count", 32'(aif.rx_count), 1);
        aif.data_out_ready = 1'b1; tick(2); aif.data_out_ready = 1'b0;
        chk("after_break_empty", 32'(aif.rx_count), 0);
        chk("after_break_ferr", 32'(aif.rx_frame_err), 0);

        // Overrun: five characters into a four-entry FIFO with no pops
        model_cnt = 0;
        for (int unsigned n = 0; n < 5; n++) begin
            if (model_cnt < DEPTH_A) begin
                q_a.push_back(32'h31 + n);
                model_cnt++;
            end
            send_a(32'h31 + n, 1'b0);
        end
        tick(TA);
        chk("ovr_count", 32'(aif.rx_count), DEPTH_A);
        chk("ovr_flag", 32'(aif.rx_overrun), 1);
        aif.data_out_ready = 1'b1; tick(8); aif.data_out_ready = 1'b0;
        chk("ovr_drained", 32'(aif.rx_count), 0);
        chk("ovr_queue", q_a.size(), 0);
        aif.err_clear = 1'b1; tick(1); aif.err_clear = 1'b0;
        chk("ovr_cleared", 32'(aif.rx_overrun), 0);

        // One-cycle glitch must be rejected as a false start
        line_a = 1'b0; tick(1); line_a = 1'b1;
        tick(2 * NA * TA);
        chk("glitch_count", 32'(aif.rx_count), 0);
        chk("glitch_flags", {29'd0, aif.rx_parity_err, aif.rx_frame_err, aif.rx_overrun}, 0);

        // Push while full coinciding with a pop: measure push latency on the filling frame
        for (int unsigned n = 0; n < 3; n++) begin
            q_a.push_back(32'h50 + n);
            send_a(32'h50 + n, 1'b0);
        end
        q_a.push_back(32'h53);
        dly = 0;
        fork
            send_a(32'h53, 1'b0);
            begin
                while (aif.rx_count != 3'(DEPTH_A) && dly < 200) begin tick(1); dly++; end
            end
        join
        chk("fill_to_full", 32'(aif.rx_count), DEPTH_A);
        if (dly == 0) dly = 1;
        q_a.push_back(32'h54);
        fork
            send_a(32'h54, 1'b0);
            begin
                tick(dly - 1);
                aif.data_out_ready = 1'b1;
                tick(1);
                aif.data_out_ready = 1'b0;
            end
        join
        tick(TA);
        chk("full_pushpop_count", 32'(aif.rx_count), DEPTH_A);
        chk("full_pushpop_no_ovr", 32'(aif.rx_overrun), 0);
        aif.data_out_ready = 1'b1; tick(8); aif.data_out_ready = 1'b0;
        chk("full_pushpop_drained", q_a.size(), 0);

        // Reset in the middle of a TX frame with a character waiting in the FIFO
        q_a.push_back(32'h77);
        send_a(32'h77, 1'b0);
        tick(TA);
        chk("pre_rst_count", 32'(aif.rx_count), 1);
        aif.data_in = 8'hA5; aif.data_in_valid = 1'b1;
        tick(1);
        aif.data_in_valid = 1'b0;
        tick(4 * TA);
        chk("mid_tx_bit4", 32'(so_a), 32'(frame_bit(32'hA5, 4, 8, 0)));
        rst = 1'b1;
        tick(1);
        chk("rst_mid_tx_line", 32'(so_a), 1);
        chk("rst_mid_tx_ready", 32'(aif.data_in_ready), 0);
        chk("rst_flush_count", 32'(aif.rx_count), 0);
        chk("rst_flush_valid", 32'(aif.data_out_valid), 0);
        q_a.delete();
        rst = 1'b0;
        tick(1);
        chk("ready_after_mid_rst", 32'(aif.data_in_ready), 1);
        tick(2 * NA * TA);
        chk("idle_after_mid_rst", 32'(so_a), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
